// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - SPARC-subset fetch stage: PC/nPC delay-slot sequencing and IF/ID latch
// Optional FETCH_PERF_CNT_EN builds the saturating fetch/annul performance counters.
module fetch_stage #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_WORD = 32'h0100_0000
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              LE,
  input  logic [31:0]       Imem_Out,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] TA,
  input  logic              Jmpl_taken,
  input  logic [ADDR_W-1:0] JA,
  input  logic              Annul,
  output logic [ADDR_W-1:0] PC_Out,
  output logic [ADDR_W-1:0] nPC_Out,
  output logic [31:0]       IF_ID_Instr,
  output logic [ADDR_W-1:0] IF_ID_PC,
  output logic              IF_ID_Valid,
  output logic              IF_ID_DSlot,
  output logic [15:0]       Fetch_cnt,
  output logic [15:0]       Annul_cnt
);

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] RESET_NPC = RESET_PC + STEP;

  typedef enum logic {SEQ, DSLOT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              redirect;
  logic [ADDR_W-1:0] npc_nxt;

  // jmpl sits in EX, so it is older than any ID branch and wins
  always_comb begin
    redirect  = Jmpl_taken | Branch_taken;
    npc_nxt   = nPC_Out + STEP;
    state_nxt = state;
    if (Jmpl_taken) begin
      npc_nxt = JA;
    end else if (Branch_taken) begin
      npc_nxt = TA;
    end
    if (LE) begin
      state_nxt = redirect ? DSLOT : SEQ;
    end
  end

  always_ff @(posedge Clk) begin
    if (R) begin
      state <= SEQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (R) begin
      PC_Out      <= RESET_PC;
      nPC_Out     <= RESET_NPC;
      IF_ID_Instr <= '0;
      IF_ID_PC    <= '0;
      IF_ID_Valid <= 1'b0;
      IF_ID_DSlot <= 1'b0;
    end else if (LE) begin
      IF_ID_Instr <= Annul ? NOP_WORD : Imem_Out;
      IF_ID_Valid <= ~Annul;
      IF_ID_PC    <= PC_Out;
      IF_ID_DSlot <= (state == DSLOT);
      PC_Out      <= nPC_Out;
      nPC_Out     <= npc_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_q;
  logic [15:0] annul_q;

  always_ff @(posedge Clk) begin
    if (R) begin
      fetch_q <= '0;
      annul_q <= '0;
    end else if (LE) begin
      if (!Annul && fetch_q != 16'hFFFF) begin
        fetch_q <= fetch_q + 16'd1;
      end
      if (Annul && annul_q != 16'hFFFF) begin
        annul_q <= annul_q + 16'd1;
      end
    end
  end

  assign Fetch_cnt = fetch_q;
  assign Annul_cnt = annul_q;
`else
  assign Fetch_cnt = 16'h0000;
  assign Annul_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (counters checked when FETCH_PERF_CNT_EN)
module tb_fetch_stage;

  localparam int          AW  = 8;
  localparam logic [31:0] NOP = 32'h0100_0000;

  logic          clk = 1'b0;
  logic          r, le, br, jm, an;
  logic [AW-1:0] ta, ja;
  logic [31:0]   imem;
  logic [AW-1:0] pc_out, npc_out, id_pc;
  logic [31:0]   id_instr;
  logic          id_valid, id_dslot;
  logic [15:0]   fetch_cnt, annul_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic [AW-1:0] id_pc;
    logic [31:0]   instr;
    logic          valid;
    logic          dslot;
    logic [15:0]   fc;
    logic [15:0]   ac;
  } exp_t;

  exp_t sb[$];

  logic [AW-1:0] m_pc, m_npc, m_idpc;
  logic [31:0]   m_instr;
  logic          m_valid, m_dslot, m_st;
  logic [15:0]   m_fc, m_ac;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return 32'hC300_0000 | {24'h0, a};
  endfunction

  assign imem = word_of(pc_out);

  fetch_stage #(.ADDR_W(AW), .RESET_PC(8'h00), .NOP_WORD(NOP)) dut (
    .Clk(clk), .R(r), .LE(le), .Imem_Out(imem),
    .Branch_taken(br), .TA(ta), .Jmpl_taken(jm), .JA(ja), .Annul(an),
    .PC_Out(pc_out), .nPC_Out(npc_out),
    .IF_ID_Instr(id_instr), .IF_ID_PC(id_pc), .IF_ID_Valid(id_valid), .IF_ID_DSlot(id_dslot),
    .Fetch_cnt(fetch_cnt), .Annul_cnt(annul_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic i_r, input logic i_le, input logic i_br, input logic [AW-1:0] i_ta,
                     input logic i_jm, input logic [AW-1:0] i_ja, input logic i_an);
    exp_t e;
    r = i_r; le = i_le; br = i_br; ta = i_ta; jm = i_jm; ja = i_ja; an = i_an;
    if (i_r) begin
      m_pc = 8'h00; m_npc = 8'h04; m_idpc = '0; m_instr = '0;
      m_valid = 1'b0; m_dslot = 1'b0; m_st = 1'b0; m_fc = '0; m_ac = '0;
    end else if (i_le) begin
      m_instr = i_an ? NOP : word_of(m_pc);
      m_valid = !i_an;
      m_idpc  = m_pc;
      m_dslot = m_st;
      m_pc    = m_npc;
      m_npc   = i_jm ? i_ja : (i_br ? i_ta : m_npc + 8'd4);
      m_st    = i_jm | i_br;
`ifdef FETCH_PERF_CNT_EN
      if (i_an && m_ac != 16'hFFFF) m_ac = m_ac + 16'd1;
      if (!i_an && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
`endif
    end
    e = '{pc: m_pc, npc: m_npc, id_pc: m_idpc, instr: m_instr,
          valid: m_valid, dslot: m_dslot, fc: m_fc, ac: m_ac};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_pc",    {24'h0, pc_out},    {24'h0, e.pc});
    check("sb_npc",   {24'h0, npc_out},   {24'h0, e.npc});
    check("sb_id_pc", {24'h0, id_pc},     {24'h0, e.id_pc});
    check("sb_instr", id_instr,           e.instr);
    check("sb_valid", {31'h0, id_valid},  {31'h0, e.valid});
    check("sb_dslot", {31'h0, id_dslot},  {31'h0, e.dslot});
    check("sb_fcnt",  {16'h0, fetch_cnt}, {16'h0, e.fc});
    check("sb_acnt",  {16'h0, annul_cnt}, {16'h0, e.ac});
  endtask

  initial begin
    logic [AW-1:0] s_pc, s_npc, s_idpc;
    logic [15:0]   a0, f0;

    cyc(1, 1, 0, 8'h00, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0, 8'h00, 0);
    check("rst_pc", {24'h0, pc_out}, 32'h00);
    check("rst_npc", {24'h0, npc_out}, 32'h04);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_instr", id_instr, 32'h0);

    cyc(0, 1, 0, 8'h00, 0, 8'h00, 0);
    check("run1_pc", {24'h0, pc_out}, 32'h04);
    check("run1_idpc", {24'h0, id_pc}, 32'h00);
    check("run1_valid", {31'h0, id_valid}, 32'h1);
    cyc(0, 1, 0, 8'h00, 0, 8'h00, 0);
    check("run2_pc", {24'h0, pc_out}, 32'h08);
    check("run2_idpc", {24'h0, id_pc}, 32'h04);

    // branch issued while PC=8, nPC=12
    cyc(0, 1, 1, 8'h40, 0, 8'h00, 0);
    check("br_pc", {24'h0, pc_out}, 32'h0C);
    check("br_npc", {24'h0, npc_out}, 32'h40);
    check("br_idpc", {24'h0, id_pc}, 32'h08);
    check("br_dslot0", {31'h0, id_dslot}, 32'h0);
    cyc(0, 1, 0, 8'h00, 0, 8'h00, 0);
    check("br_pc2", {24'h0, pc_out}, 32'h40);
    check("br_npc2", {24'h0, npc_out}, 32'h44);
    check("br_ds_pc", {24'h0, id_pc}, 32'h0C);
    check("br_dslot1", {31'h0, id_dslot}, 32'h1);
    cyc(0, 1, 0, 8'h00, 0, 8'h00, 0);
    check("br_tgt_idpc", {24'h0, id_pc}, 32'h40);
    check("br_dslot2", {31'h0, id_dslot}, 32'h0);

    // jmpl and branch together: jmpl wins
    cyc(0, 1, 1, 8'h40, 1, 8'h80, 0);
    check("prio_npc", {24'h0, npc_out}, 32'h80);

    // annulled delay slot
    a0 = annul_cnt; f0 = fetch_cnt;
    cyc(0, 1, 0, 8'h00, 0, 8'h00, 1);
    check("ann_instr", id_instr, NOP);
    check("ann_valid", {31'h0, id_valid}, 32'h0);
    check("ann_dslot", {31'h0, id_dslot}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check("ann_acnt", {16'h0, annul_cnt}, {16'h0, a0 + 16'd1});
    check("ann_fcnt", {16'h0, fetch_cnt}, {16'h0, f0});
`else
    check("ann_acnt", {16'h0, annul_cnt}, 32'h0);
    check("ann_fcnt", {16'h0, fetch_cnt}, 32'h0);
`endif

    // stall with a branch pulse that must be lost
    cyc(0, 1, 0, 8'h00, 0, 8'h00, 0);
    s_pc = pc_out; s_npc = npc_out; s_idpc = id_pc;
    cyc(0, 0, 0, 8'h00, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h20, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 0, 8'h00, 0);
    check("stall_pc", {24'h0, pc_out}, {24'h0, s_pc});
    check("stall_npc", {24'h0, npc_out}, {24'h0, s_npc});
    check("stall_idpc", {24'h0, id_pc}, {24'h0, s_idpc});
    cyc(0, 1, 0, 8'h00, 0, 8'h00, 0);
    check("stall_lost", {24'h0, npc_out}, {24'h0, s_npc + 8'd4});
    check("stall_no_ds", {31'h0, id_dslot}, 32'h0);
    cyc(0, 0, 0, 8'h00, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0, 8'h00, 0);
    check("stall_rst_pc", {24'h0, pc_out}, 32'h00);
    check("stall_rst_npc", {24'h0, npc_out}, 32'h04);

    // reach PC=F8 nPC=FC through a DCTI couple, then wrap
    cyc(0, 1, 1, 8'hF8, 0, 8'h00, 0);
    cyc(0, 1, 1, 8'hFC, 0, 8'h00, 0);
    check("wrap_pre_pc", {24'h0, pc_out}, 32'hF8);
    check("wrap_pre_npc", {24'h0, npc_out}, 32'hFC);
    cyc(0, 1, 0, 8'h00, 0, 8'h00, 0);
    check("wrap_pc1", {24'h0, pc_out}, 32'hFC);
    check("wrap_npc1", {24'h0, npc_out}, 32'h00);
    check("wrap_dslot", {31'h0, id_dslot}, 32'h1);
    cyc(0, 1, 0, 8'h00, 0, 8'h00, 0);
    check("wrap_pc2", {24'h0, pc_out}, 32'h00);
    check("wrap_npc2", {24'h0, npc_out}, 32'h04);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          AW'($urandom), $urandom_range(0, 7) == 0, AW'($urandom), $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
